// File: rtl/axi_tb_chan_agent.sv
// axi_tb_chan_agent
//   Testbench-side valid/ready channel agent with NUM_CH independent channels.
//   Each channel has a DEPTH-entry transmit queue that feeds an AXI-style VALID
//   driver, plus a receive capture register with a sticky new-data flag.
//   Transfer counters and a sticky overflow flag are kept per channel.
//   Ports (slice i of any vector belongs to channel i):
//     ACLK, ARESET            clock, synchronous active-high reset
//     push/push_data          enqueue into tx queue; full/ovf report queue state
//     tx_en                   permit new transfers to start
//     tx_valid/tx_data        registered VALID/payload; tx_ready from the bus
//     rx_valid/rx_data        from the bus; rx_hold backpressure -> rx_ready
//     rx_q/new_data           last capture and its sticky flag; new_data_clr clears
//     tx_cnt/rx_cnt           completed handshakes, wrapping

module axi_tb_chan_lane #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              ovf,
  input  logic              tx_en,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_hold,
  output logic              rx_ready,
  output logic [DATA_W-1:0] rx_q,
  output logic              new_data,
  input  logic              new_data_clr,
  output logic [CNT_W-1:0]  tx_cnt,
  output logic [CNT_W-1:0]  rx_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                empty, push_ok, pop, tx_done, rx_cap;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // full is the registered view, so a push in the same cycle as a pop from a
  // full queue is still dropped.
  assign push_ok = push & ~full;
  assign tx_done = (state == DRIVE) & tx_ready;
  assign rx_ready = ~rx_hold;
  assign rx_cap  = rx_valid & ~rx_hold;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state; pop is decided here since it is what moves the FSM
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (tx_en && !empty) begin
        pop       = 1'b1;
        state_nxt = DRIVE;
      end
      DRIVE: if (tx_ready) begin
        // tx_en only gates the next start; a VALID already up stays up
        if (tx_en && !empty) pop = 1'b1;
        else                 state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: VALID is a pure decode of the state register
  always_comb begin
    tx_valid = (state == DRIVE);
  end

  // queue storage carries no reset; count/pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      tx_data  <= '0;
      tx_cnt   <= '0;
      rx_q     <= '0;
      new_data <= 1'b0;
      rx_cnt   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full) ovf <= 1'b1;
      if (tx_done) tx_cnt <= tx_cnt + 1'b1;
      // capture beats a same-cycle clear
      if (rx_cap) begin
        rx_q     <= rx_data;
        new_data <= 1'b1;
        rx_cnt   <= rx_cnt + 1'b1;
      end else if (new_data_clr) begin
        new_data <= 1'b0;
      end
    end
  end
endmodule

module axi_tb_chan_agent #(
  parameter int DATA_W = 64,
  parameter int NUM_CH = 5,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [NUM_CH-1:0]        push,
  input  logic [NUM_CH*DATA_W-1:0] push_data,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        ovf,
  input  logic [NUM_CH-1:0]        tx_en,
  output logic [NUM_CH-1:0]        tx_valid,
  output logic [NUM_CH*DATA_W-1:0] tx_data,
  input  logic [NUM_CH-1:0]        tx_ready,
  input  logic [NUM_CH-1:0]        rx_valid,
  input  logic [NUM_CH*DATA_W-1:0] rx_data,
  input  logic [NUM_CH-1:0]        rx_hold,
  output logic [NUM_CH-1:0]        rx_ready,
  output logic [NUM_CH*DATA_W-1:0] rx_q,
  output logic [NUM_CH-1:0]        new_data,
  input  logic [NUM_CH-1:0]        new_data_clr,
  output logic [NUM_CH*CNT_W-1:0]  tx_cnt,
  output logic [NUM_CH*CNT_W-1:0]  rx_cnt
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    axi_tb_chan_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane (
      .clk          (ACLK),
      .rst          (ARESET),
      .push         (push[i]),
      .push_data    (push_data[i*DATA_W +: DATA_W]),
      .full         (full[i]),
      .ovf          (ovf[i]),
      .tx_en        (tx_en[i]),
      .tx_valid     (tx_valid[i]),
      .tx_data      (tx_data[i*DATA_W +: DATA_W]),
      .tx_ready     (tx_ready[i]),
      .rx_valid     (rx_valid[i]),
      .rx_data      (rx_data[i*DATA_W +: DATA_W]),
      .rx_hold      (rx_hold[i]),
      .rx_ready     (rx_ready[i]),
      .rx_q         (rx_q[i*DATA_W +: DATA_W]),
      .new_data     (new_data[i]),
      .new_data_clr (new_data_clr[i]),
      .tx_cnt       (tx_cnt[i*CNT_W +: CNT_W]),
      .rx_cnt       (rx_cnt[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_axi_tb_chan_agent.sv
// Directed bench for axi_tb_chan_agent: one task per scenario, inline checks.
module tb_axi_tb_chan_agent;
  localparam int DW = 64, NC = 5, DP = 4, CW = 16;

  logic              ACLK = 0, ARESET;
  logic [NC-1:0]     push, full, ovf, tx_en, tx_valid, tx_ready;
  logic [NC-1:0]     rx_valid, rx_hold, rx_ready, new_data, new_data_clr;
  logic [NC*DW-1:0]  push_data, tx_data, rx_data, rx_q;
  logic [NC*CW-1:0]  tx_cnt, rx_cnt;

  int total = 0, bad = 0;

  axi_tb_chan_agent #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(DP), .CNT_W(CW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .push(push), .push_data(push_data),
    .full(full), .ovf(ovf), .tx_en(tx_en), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_hold(rx_hold), .rx_ready(rx_ready), .rx_q(rx_q),
    .new_data(new_data), .new_data_clr(new_data_clr), .tx_cnt(tx_cnt),
    .rx_cnt(rx_cnt)
  );

  always #5 ACLK = ~ACLK;

  // advance one edge; inputs are driven and outputs sampled 1 time unit after it
  task automatic step();
    @(posedge ACLK); #1;
  endtask

  function automatic logic [DW-1:0] dsl(input logic [NC*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction
  function automatic logic [CW-1:0] csl(input logic [NC*CW-1:0] v, input int i);
    return v[i*CW +: CW];
  endfunction

  task automatic set_push(input int ch, input logic [DW-1:0] d);
    push = '0; push_data = '0;
    push[ch] = 1'b1;
    push_data[ch*DW +: DW] = d;
  endtask

  task automatic test_reset();
    ARESET = 1; step(); step(); ARESET = 0;
    total++; if (tx_valid !== 5'h0) begin bad++; $display("FAIL rst_tx_valid got=%h exp=0", tx_valid); end
    total++; if (full !== 5'h0 || ovf !== 5'h0) begin bad++; $display("FAIL rst_full_ovf got=%h/%h exp=0/0", full, ovf); end
    total++; if (new_data !== 5'h0 || rx_q !== '0 || tx_data !== '0) begin bad++; $display("FAIL rst_data got nd=%h", new_data); end
    total++; if (tx_cnt !== '0 || rx_cnt !== '0) begin bad++; $display("FAIL rst_cnt got=%h/%h exp=0", tx_cnt, rx_cnt); end
    total++; if (rx_ready !== 5'h1f) begin bad++; $display("FAIL rst_rx_ready got=%h exp=1f", rx_ready); end
  endtask

  task automatic test_single();
    tx_en = 5'h02; tx_ready = 5'h1f;
    set_push(1, 64'hA5); step(); push = '0;
    total++; if (tx_valid !== 5'h00) begin bad++; $display("FAIL single_lat got=%h exp=00", tx_valid); end
    step();
    total++; if (tx_valid !== 5'h02) begin bad++; $display("FAIL single_valid got=%h exp=02", tx_valid); end
    total++; if (dsl(tx_data, 1) !== 64'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", dsl(tx_data, 1)); end
    step();
    total++; if (tx_valid !== 5'h00) begin bad++; $display("FAIL single_drop got=%h exp=00", tx_valid); end
    total++; if (csl(tx_cnt, 1) !== 16'd1 || csl(tx_cnt, 0) !== 16'd0) begin bad++; $display("FAIL single_cnt got=%h exp=1", tx_cnt); end
  endtask

  task automatic test_full_b2b();
    tx_en = 5'h00; tx_ready = 5'h1f;
    for (int k = 1; k <= 4; k++) begin set_push(0, 64'(k)); step(); end
    total++; if (full[0] !== 1'b1 || ovf[0] !== 1'b0) begin bad++; $display("FAIL q_full got full=%b ovf=%b exp=1/0", full[0], ovf[0]); end
    set_push(0, 64'd5); step(); push = '0;
    total++; if (ovf[0] !== 1'b1 || full[0] !== 1'b1) begin bad++; $display("FAIL q_ovf got ovf=%b full=%b exp=1/1", ovf[0], full[0]); end
    tx_en = 5'h01;
    for (int k = 1; k <= 4; k++) begin
      step();
      total++; if (tx_valid[0] !== 1'b1 || dsl(tx_data, 0) !== 64'(k)) begin
        bad++; $display("FAIL b2b_beat%0d got v=%b d=%h exp=1/%h", k, tx_valid[0], dsl(tx_data, 0), k); end
    end
    total++; if (full[0] !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b exp=0", full[0]); end
    step();
    total++; if (tx_valid[0] !== 1'b0 || csl(tx_cnt, 0) !== 16'd4) begin
      bad++; $display("FAIL b2b_end got v=%b cnt=%0d exp=0/4", tx_valid[0], csl(tx_cnt, 0)); end
    tx_en = 5'h00;
  endtask

  task automatic test_no_retract();
    tx_en = 5'h08; tx_ready = 5'h00;
    set_push(3, 64'h77); step(); push = '0; step();
    total++; if (tx_valid[3] !== 1'b1) begin bad++; $display("FAIL hold_start got=%b exp=1", tx_valid[3]); end
    tx_en = 5'h00;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (tx_valid[3] !== 1'b1 || dsl(tx_data, 3) !== 64'h77) begin
        bad++; $display("FAIL hold_cyc%0d got v=%b d=%h exp=1/77", k, tx_valid[3], dsl(tx_data, 3)); end
    end
    tx_ready = 5'h08; step(); tx_ready = 5'h00;
    total++; if (tx_valid[3] !== 1'b0 || csl(tx_cnt, 3) !== 16'd1) begin
      bad++; $display("FAIL hold_done got v=%b cnt=%0d exp=0/1", tx_valid[3], csl(tx_cnt, 3)); end
  endtask

  task automatic test_rx_hold();
    rx_hold = 5'h04; rx_valid = 5'h04; rx_data = '0; rx_data[2*DW +: DW] = 64'h1234; #1;
    total++; if (rx_ready[2] !== 1'b0) begin bad++; $display("FAIL rx_ready_held got=%b exp=0", rx_ready[2]); end
    step();
    total++; if (new_data[2] !== 1'b0 || csl(rx_cnt, 2) !== 16'd0 || dsl(rx_q, 2) !== '0) begin
      bad++; $display("FAIL rx_nocap got nd=%b cnt=%0d exp=0/0", new_data[2], csl(rx_cnt, 2)); end
    rx_hold = 5'h00; #1;
    total++; if (rx_ready[2] !== 1'b1) begin bad++; $display("FAIL rx_ready_rel got=%b exp=1", rx_ready[2]); end
    step(); rx_valid = 5'h00;
    total++; if (dsl(rx_q, 2) !== 64'h1234 || new_data[2] !== 1'b1 || csl(rx_cnt, 2) !== 16'd1) begin
      bad++; $display("FAIL rx_cap got q=%h nd=%b cnt=%0d exp=1234/1/1", dsl(rx_q, 2), new_data[2], csl(rx_cnt, 2)); end
  endtask

  task automatic test_clr_vs_set();
    rx_valid = 5'h01; rx_data = '0; rx_data[DW-1:0] = 64'hBEEF; new_data_clr = 5'h01;
    step(); rx_valid = 5'h00;
    total++; if (new_data[0] !== 1'b1 || dsl(rx_q, 0) !== 64'hBEEF) begin
      bad++; $display("FAIL clr_set got nd=%b q=%h exp=1/beef", new_data[0], dsl(rx_q, 0)); end
    step(); new_data_clr = 5'h00;
    total++; if (new_data[0] !== 1'b0 || new_data[2] !== 1'b1) begin
      bad++; $display("FAIL clr_only got nd=%b exp=00100", new_data); end
  endtask

  task automatic test_reset_mid();
    tx_en = 5'h00; tx_ready = 5'h00;
    for (int k = 0; k < 3; k++) begin set_push(4, 64'h41 + 64'(k)); step(); end
    push = '0; tx_en = 5'h10; step();
    total++; if (tx_valid[4] !== 1'b1 || dsl(tx_data, 4) !== 64'h41) begin
      bad++; $display("FAIL mid_drive got v=%b d=%h exp=1/41", tx_valid[4], dsl(tx_data, 4)); end
    ARESET = 1; step(); ARESET = 0;
    total++; if (tx_valid !== 5'h0 || full !== 5'h0 || ovf !== 5'h0 || new_data !== 5'h0) begin
      bad++; $display("FAIL mid_rst got v=%h f=%h o=%h nd=%h exp=0", tx_valid, full, ovf, new_data); end
    total++; if (tx_cnt !== '0 || rx_cnt !== '0) begin bad++; $display("FAIL mid_rst_cnt got=%h/%h exp=0", tx_cnt, rx_cnt); end
    tx_ready = 5'h10; set_push(4, 64'h99); step(); push = '0; step();
    total++; if (tx_valid[4] !== 1'b1 || dsl(tx_data, 4) !== 64'h99) begin
      bad++; $display("FAIL post_rst got v=%b d=%h exp=1/99", tx_valid[4], dsl(tx_data, 4)); end
    step();
    total++; if (tx_valid[4] !== 1'b0 || csl(tx_cnt, 4) !== 16'd1) begin
      bad++; $display("FAIL post_rst_end got v=%b cnt=%0d exp=0/1", tx_valid[4], csl(tx_cnt, 4)); end
  endtask

  initial begin
    ARESET = 1; push = '0; push_data = '0; tx_en = '0; tx_ready = '0;
    rx_valid = '0; rx_data = '0; rx_hold = '0; new_data_clr = '0;
    #1;
    test_reset();
    test_single();
    test_full_b2b();
    test_no_retract();
    test_rx_hold();
    test_clr_vs_set();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
